tensor_core_matmul_sequencer: RTL
=================================

// Module: tensor_core_matmul_sequencer
// PURPOSE
//  Downstream consumer of the tensor-core register file: multiplies the 4x4 matrix in bank 0 (A)
//  by the 4x4 matrix in bank 1 (B), one output element per cycle. It returns C = A*B as a
//  saturated 4x4 result on a bulk-write bus. That bus drives the register file's bulk write port,
//  so C lands in bank 0 and B is written back unchanged to bank 1.
// PARAMETERS
//  DATA_WIDTH    8  width of each matrix element, signed two's complement
//  OUTPUT_SHIFT  0  arithmetic right shift applied to each dot product before saturation (0..8)
// PORTS
//  clock_in                 in   1              single clock, all state updates on rising edge
//  reset_n_in               in   1              synchronous reset, active-low
//  start_in                 in   1              request a multiply; accepted only in IDLE
//  matrix_a_in              in   [4][4]xDW      A, wired from register-file read_data_out[0]
//  matrix_b_in              in   [4][4]xDW      B, wired from register-file read_data_out[1]
//  busy_out                 out  1              high in COMPUTE and WRITE
//  done_out                 out  1              one-cycle pulse, coincident with the write
//  bulk_write_enable_out    out  1              one-cycle pulse to the register-file bulk write enable
//  bulk_write_data_out      out  [2][4][4]xDW   [0] = C, [1] = latched B
// BEHAVIOUR
//  Reset: reset_n_in low at a rising edge has these effects:
//   - state goes to IDLE and the element counter to 0;
//   - C and the operand snapshots are cleared to 0;
//   - busy_out, done_out and bulk_write_enable_out are 0.
//  Reset wins over every other input and aborts an operation mid-COMPUTE or mid-WRITE; no write is issued.
//  FSM IDLE -> COMPUTE -> WRITE -> IDLE:
//   - IDLE: when start_in=1, snapshot matrix_a_in and matrix_b_in into internal registers, clear C
//     and the counter, then go to COMPUTE. Inputs are ignored after the snapshot.
//   - COMPUTE: counter k runs 0..15, with row r = k/4 and column c = k%4.
//     Each cycle, C[r][c] <= sat(asr(sum_{i=0..3} A[r][i]*B[i][c], OUTPUT_SHIFT)).
//     After k=15, go to WRITE. This state lasts exactly 16 cycles.
//   - WRITE: one cycle with bulk_write_enable_out=1 and done_out=1, then return to IDLE.
//  Arithmetic:
//   - Each product is signed, 2*DW bits. The sum of 4 products is signed, 2*DW+2 bits; it cannot overflow.
//   - The shift is arithmetic, so it rounds toward -inf.
//   - Saturation clamps to [-2^(DW-1), 2^(DW-1)-1], i.e. [-128, 127] at the default width.
//  Latency: start accepted at edge 0; busy_out is high from edge 1; C[3][3] is written at edge 16;
//   the WRITE cycle follows edge 16, so done and the write are seen at edge 17; IDLE at edge 18.
//   Total 18 edges from start to idle.
//  bulk_write_data_out is driven from registers at all times. It holds the last C and B after done,
//   and shows partial C during COMPUTE; the consumer qualifies it with bulk_write_enable_out only.
//  start_in while busy_out=1 is ignored (not queued). start_in held high re-triggers in the first IDLE cycle.
//  Snapshotting is required: the register file may be written by other masters during COMPUTE.
//  Element order is row-major. An unwritten C element reads 0 during COMPUTE.
// TESTING
//  1. A=identity(1 on diagonal), B[i][j]=4i+j-8; start -> write at edge 17, C==B,
//     bulk_write_data_out[1]==B, done_out high exactly 1 cycle.
//  2. A=all 127, B=all 127; start -> every C element == 127 (saturated; raw sum 64516).
//  3. A=all -128, B=all 127 -> every C = -128; A=all -128, B=all -128 -> every C = 127.
//  4. OUTPUT_SHIFT=2, A=all 3, B=all -1 -> raw -12, shifted -3, so every C = -3;
//     raw sum -1 (A[0][0]=1, B[0][0]=-1, rest 0) -> C[0][0] = -1 (rounds toward -inf).
//  5. start at edge 0, pulse start again at edges 5 and 17 -> only one write (edge 17);
//     a start at edge 18 (IDLE) begins a new run with write at edge 35.
//  6. Change matrix_a_in/b_in after edge 0 -> C still equals the product of the snapshot.
//     Drive reset_n_in low at edge 8 -> no write/done pulse; outputs 0; a fresh start works normally.

Source files
------------

// File: rtl/tensor_core_matmul_sequencer_if.sv
// Bus between the matmul sequencer and its environment: start request,
// operand matrices from the register file, status and the bulk-write port.
interface tensor_core_matmul_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                                 start_in;
    logic [3:0][3:0][DATA_WIDTH-1:0]      matrix_a_in;
    logic [3:0][3:0][DATA_WIDTH-1:0]      matrix_b_in;
    logic                                 busy_out;
    logic                                 done_out;
    logic                                 bulk_write_enable_out;
    logic [1:0][3:0][3:0][DATA_WIDTH-1:0] bulk_write_data_out;

    modport master (
        input  start_in,
        input  matrix_a_in,
        input  matrix_b_in,
        output busy_out,
        output done_out,
        output bulk_write_enable_out,
        output bulk_write_data_out
    );

    modport slave (
        output start_in,
        output matrix_a_in,
        output matrix_b_in,
        input  busy_out,
        input  done_out,
        input  bulk_write_enable_out,
        input  bulk_write_data_out
    );
endinterface

// File: rtl/tensor_core_matmul_sequencer.sv
// Sequential 4x4 signed matrix multiply C = A*B, one element per cycle in
// row-major order, with optional arithmetic right shift and saturation.
// C and the snapshotted B are presented on the register-file bulk-write bus.
module tensor_core_matmul_sequencer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned OUTPUT_SHIFT = 0
) (
    input logic                           clock_in,
    input logic                           reset_n_in,
    tensor_core_matmul_sequencer_if.master bus
);
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned SUM_W  = PROD_W + 2;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (DATA_WIDTH - 1)));

    typedef logic [3:0][3:0][DATA_WIDTH-1:0] matrix_t;
    typedef enum logic [1:0] {IDLE, COMPUTE, WRITE} state_t;

    state_t                  state_q, state_d;
    matrix_t                 a_q, b_q, c_q;
    logic [3:0]              k_q;
    logic [1:0]              row, col;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  dot, shifted;
    logic [DATA_WIDTH-1:0]   elem;
    logic                    busy, done, write_en;

    assign row = k_q[3:2];
    assign col = k_q[1:0];

    // State register; reset aborts any operation in flight
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Next-state and status decode
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        write_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_in) state_d = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (k_q == 4'd15) state_d = WRITE;
            end
            WRITE: begin
                busy     = 1'b1;
                done     = 1'b1;
                write_en = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Dot product of row r of A and column c of B, shifted and saturated
    always_comb begin
        prod = '0;
        dot  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            prod = PROD_W'($signed(a_q[row][i[1:0]])) * PROD_W'($signed(b_q[i[1:0]][col]));
            dot  = dot + SUM_W'(prod);
        end
        shifted = dot >>> OUTPUT_SHIFT;
        if (shifted > SAT_MAX)      elem = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN) elem = SAT_MIN[DATA_WIDTH-1:0];
        else                        elem = shifted[DATA_WIDTH-1:0];
    end

    // Operand snapshot, result accumulation and element counter
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            k_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_in) begin
                        a_q <= bus.matrix_a_in;
                        b_q <= bus.matrix_b_in;
                        c_q <= '0;
                        k_q <= '0;
                    end
                end
                COMPUTE: begin
                    c_q[row][col] <= elem;
                    k_q           <= k_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_out               = busy;
    assign bus.done_out               = done;
    assign bus.bulk_write_enable_out  = write_en;
    assign bus.bulk_write_data_out[0] = c_q;
    assign bus.bulk_write_data_out[1] = b_q;
endmodule
